// File: rtl/fifo_prom_frame_ctrl_pkg.sv
// Shared types and constants for the averaging-result FIFO frame-capture controller.
package fifo_prom_ctrl_pkg;

    // Capture state. The encoding is visible to software through STATUS[1:0].
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam int CSR_ADDR_W  = 2;
    localparam int CSR_DATA_W  = 32;
    localparam int FRAME_LEN_W = 16;
    localparam int CNT_W       = 16;

    // CSR word addresses
    localparam logic [CSR_ADDR_W-1:0] ADDR_CTRL      = 2'd0;
    localparam logic [CSR_ADDR_W-1:0] ADDR_STATUS    = 2'd1;
    localparam logic [CSR_ADDR_W-1:0] ADDR_FRAME_LEN = 2'd2;
    localparam logic [CSR_ADDR_W-1:0] ADDR_COUNT     = 2'd3;

    // CTRL bit positions
    localparam int CTRL_ARM     = 0;
    localparam int CTRL_ABORT   = 1;
    localparam int CTRL_ACK     = 2;
    localparam int CTRL_CONT    = 3;
    localparam int CTRL_CLR_OVF = 4;
    localparam int CTRL_IE      = 5;

    // STATUS bit positions
    localparam int STAT_STATE_LSB = 0;
    localparam int STAT_DONE      = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_LEVEL_LSB = 8;
    localparam int STAT_DROP_LSB  = 16;

endpackage

// File: rtl/fifo_prom_frame_ctrl_if.sv
// Avalon-MM CSR bus between a host (master) and the frame-capture controller (slave).
interface fifo_prom_frame_ctrl_if;
    import fifo_prom_ctrl_pkg::*;

    logic [CSR_ADDR_W-1:0] address;
    logic                  write;
    logic                  read;
    logic [CSR_DATA_W-1:0] writedata;
    logic [CSR_DATA_W-1:0] readdata;

    modport master (output address, write, read, writedata, input readdata);
    modport slave  (input address, write, read, writedata, output readdata);
endinterface

// File: rtl/fifo_prom_frame_ctrl_level_tracker.sv
// FIFO occupancy counter: counts up on accepted samples, down on reads the FIFO honours.
module fifo_prom_level_tracker
    import fifo_prom_ctrl_pkg::*;
#(
    parameter int DEPTH   = 128,
    parameter int LEVEL_W = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               inc,
    input  logic               dec,
    output logic [LEVEL_W-1:0] level,
    output logic               full
);

    logic [LEVEL_W-1:0] level_q;
    logic [LEVEL_W-1:0] level_d;

    // Simultaneous increment and decrement cancel; never step below zero.
    always_comb begin
        level_d = level_q;
        if (inc && !dec) begin
            level_d = level_q + LEVEL_W'(1);
        end else if (!inc && dec && (level_q != '0)) begin
            level_d = level_q - LEVEL_W'(1);
        end
    end

    // Occupancy register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;
    assign full  = (level_q == LEVEL_W'(DEPTH));

endmodule

// File: rtl/fifo_prom_frame_ctrl.sv
// Frame-capture controller gating the averaging stream into the result FIFO.
// Optional feature macro: FIFO_PROM_FRAME_IRQ_EN adds a registered irq = done & ie
// output and makes CTRL.ie a stored, readable bit.
module fifo_prom_frame_ctrl
    import fifo_prom_ctrl_pkg::*;
#(
    parameter int DATA_W            = 32,
    parameter int DEPTH             = 128,
    parameter int LEVEL_W           = 8,
    parameter int FRAME_LEN_DEFAULT = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_valid,
    output logic [DATA_W-1:0] fifo_data,
    output logic              fifo_wrreq,
    input  logic              fifo_empty,
    input  logic              fifo_rdreq_mon,
    fifo_prom_frame_ctrl_if.slave csr,
    output logic              frame_done
`ifdef FIFO_PROM_FRAME_IRQ_EN
    ,
    output logic              irq
`endif
);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]       frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]       drop_cnt_q, drop_cnt_d;
    logic [FRAME_LEN_W-1:0] frame_len_q, frame_len_d;
    logic                   done_q, done_d;
    logic                   ovf_q, ovf_d;
    logic                   cont_q, cont_d;
    logic                   ie_q, ie_d;
    logic                   fifo_wrreq_q, fifo_wrreq_d;
    logic [DATA_W-1:0]      fifo_data_q, fifo_data_d;
    logic [CSR_DATA_W-1:0]  readdata_q, readdata_d;
    logic [CSR_DATA_W-1:0]  ctrl_rd;
    logic [CNT_W-1:0]       sample_inc;
    logic [LEVEL_W-1:0]     level;
    logic                   level_full;
    logic                   rd_ok;
    logic                   accept;
    logic                   reject;
    logic                   unused_wdata;

    // A read in the same cycle frees a slot, so a full FIFO can still take a sample.
    assign rd_ok        = fifo_rdreq_mon & ~fifo_empty;
    assign accept       = (state_q == ST_CAPTURE) & src_valid & (~level_full | rd_ok);
    assign reject       = (state_q == ST_CAPTURE) & src_valid & level_full & ~rd_ok;
    assign sample_inc   = sample_cnt_q + CNT_W'(1);
    assign unused_wdata = ^csr.writedata[CSR_DATA_W-1:FRAME_LEN_W];

    fifo_prom_level_tracker #(
        .DEPTH   (DEPTH),
        .LEVEL_W (LEVEL_W)
    ) u_level (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (accept),
        .dec     (rd_ok),
        .level   (level),
        .full    (level_full)
    );

    // Next-state: sample acceptance and frame end first, then CSR commands override.
    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        frame_len_d  = frame_len_q;
        done_d       = done_q;
        ovf_d        = ovf_q;
        cont_d       = cont_q;
        ie_d         = ie_q;
        fifo_wrreq_d = accept;
        fifo_data_d  = accept ? src_data : fifo_data_q;
        readdata_d   = readdata_q;
        ctrl_rd      = '0;

        if (accept) begin
            sample_cnt_d = sample_inc;
            if ((frame_len_q != '0) && (sample_inc == frame_len_q)) begin
                done_d = 1'b1;
                if (cont_q) begin
                    sample_cnt_d = '0;
                    frame_cnt_d  = frame_cnt_q + CNT_W'(1);
                end else begin
                    state_d = ST_DONE;
                end
            end
        end

        if (reject) begin
            ovf_d = 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end

        if (csr.write) begin
            case (csr.address)
                ADDR_CTRL: begin
                    cont_d = csr.writedata[CTRL_CONT];
`ifdef FIFO_PROM_FRAME_IRQ_EN
                    ie_d = csr.writedata[CTRL_IE];
`endif
                    if (csr.writedata[CTRL_ABORT]) begin
                        state_d = ST_IDLE;
                    end else if (csr.writedata[CTRL_ARM]) begin
                        state_d      = ST_CAPTURE;
                        sample_cnt_d = '0;
                        done_d       = 1'b0;
                    end else if (csr.writedata[CTRL_ACK] && (state_q == ST_DONE)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b0;
                    end
                    if (csr.writedata[CTRL_CLR_OVF]) begin
                        ovf_d      = 1'b0;
                        drop_cnt_d = '0;
                    end
                end
                ADDR_FRAME_LEN: frame_len_d = csr.writedata[FRAME_LEN_W-1:0];
                default: ;
            endcase
        end

        ctrl_rd[CTRL_CONT] = cont_q;
        ctrl_rd[CTRL_IE]   = ie_q;

        if (csr.read) begin
            case (csr.address)
                ADDR_CTRL:      readdata_d = ctrl_rd;
                ADDR_STATUS:    readdata_d = {drop_cnt_q, 8'(level), 4'b0000, ovf_q, done_q, state_q};
                ADDR_FRAME_LEN: readdata_d = {{(CSR_DATA_W-FRAME_LEN_W){1'b0}}, frame_len_q};
                default:        readdata_d = {frame_cnt_q, sample_cnt_q};
            endcase
        end
    end

    // State and register bank
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            sample_cnt_q <= '0;
            frame_cnt_q  <= '0;
            drop_cnt_q   <= '0;
            frame_len_q  <= FRAME_LEN_W'(FRAME_LEN_DEFAULT);
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            cont_q       <= 1'b0;
            ie_q         <= 1'b0;
            fifo_wrreq_q <= 1'b0;
            fifo_data_q  <= '0;
            readdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            frame_len_q  <= frame_len_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
            cont_q       <= cont_d;
            ie_q         <= ie_d;
            fifo_wrreq_q <= fifo_wrreq_d;
            fifo_data_q  <= fifo_data_d;
            readdata_q   <= readdata_d;
        end
    end

    assign fifo_wrreq   = fifo_wrreq_q;
    assign fifo_data    = fifo_data_q;
    assign csr.readdata = readdata_q;
    assign frame_done   = done_q;

`ifdef FIFO_PROM_FRAME_IRQ_EN
    logic irq_q, irq_d;

    // Interrupt tracks the next done/ie values so it lines up with frame_done.
    always_comb begin
        irq_d = done_d & ie_d;
    end

    // Interrupt register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_fifo_prom_frame_ctrl.sv
// Directed bench for fifo_prom_frame_ctrl with a scoreboard of expected FIFO writes.
// Covers FIFO_PROM_FRAME_IRQ_EN when the macro is defined.
module tb_fifo_prom_frame_ctrl;
    import fifo_prom_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] src_data;
    logic        src_valid;
    logic [31:0] fifo_data;
    logic        fifo_wrreq;
    logic        fifo_empty;
    logic        fifo_rdreq_mon;
    logic        frame_done;
`ifdef FIFO_PROM_FRAME_IRQ_EN
    logic        irq;
`endif

    int          assert_count = 0;
    int          fail_count   = 0;
    int          wr_count     = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_data;
    logic [31:0] rd_val;

    fifo_prom_frame_ctrl_if csr_if ();

    fifo_prom_frame_ctrl dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .src_data       (src_data),
        .src_valid      (src_valid),
        .fifo_data      (fifo_data),
        .fifo_wrreq     (fifo_wrreq),
        .fifo_empty     (fifo_empty),
        .fifo_rdreq_mon (fifo_rdreq_mon),
        .csr            (csr_if.slave),
        .frame_done     (frame_done)
`ifdef FIFO_PROM_FRAME_IRQ_EN
        ,
        .irq            (irq)
`endif
    );

    always #5 clock = ~clock;

    // Every FIFO write must match the oldest sample the bench expected to be accepted.
    always @(negedge clock) begin
        if (reset_n && fifo_wrreq) begin
            wr_count++;
            assert_count++;
            if (exp_q.size() == 0) begin
                fail_count++;
                $error("[TB] FAIL unexpected_write observed=%08h expected=none", fifo_data);
            end else begin
                exp_data = exp_q.pop_front();
                assert (fifo_data === exp_data) else begin
                    fail_count++;
                    $error("[TB] FAIL fifo_data observed=%08h expected=%08h", fifo_data, exp_data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] d, input logic v, input logic rd,
                                 input logic empty, input logic exp_accept);
        src_data       = d;
        src_valid      = v;
        fifo_rdreq_mon = rd;
        fifo_empty     = empty;
        if (exp_accept) exp_q.push_back(d);
        tick();
        src_valid      = 1'b0;
        fifo_rdreq_mon = 1'b0;
        fifo_empty     = 1'b1;
    endtask

    task automatic csrWrite(input logic [1:0] addr, input logic [31:0] data);
        csr_if.address   = addr;
        csr_if.writedata = data;
        csr_if.write     = 1'b1;
        tick();
        csr_if.write     = 1'b0;
    endtask

    task automatic csrRead(input logic [1:0] addr, output logic [31:0] data);
        csr_if.address = addr;
        csr_if.read    = 1'b1;
        tick();
        csr_if.read    = 1'b0;
        data           = csr_if.readdata;
    endtask

    task automatic readCheck(input string tag, input logic [1:0] addr, input logic [31:0] expected);
        logic [31:0] v;
        csrRead(addr, v);
        checkOutput(tag, v, expected);
    endtask

    initial begin
        reset_n          = 1'b0;
        src_data         = '0;
        src_valid        = 1'b0;
        fifo_empty       = 1'b1;
        fifo_rdreq_mon   = 1'b0;
        csr_if.address   = '0;
        csr_if.write     = 1'b0;
        csr_if.read      = 1'b0;
        csr_if.writedata = '0;

        // Reset values
        repeat (3) tick();
        checkOutput("rst_wrreq", {31'd0, fifo_wrreq}, 32'd0);
        checkOutput("rst_fifo_data", fifo_data, 32'd0);
        checkOutput("rst_readdata", csr_if.readdata, 32'd0);
        checkOutput("rst_frame_done", {31'd0, frame_done}, 32'd0);
`ifdef FIFO_PROM_FRAME_IRQ_EN
        checkOutput("rst_irq", {31'd0, irq}, 32'd0);
`endif
        reset_n = 1'b1;
        tick();
        readCheck("rst_status", ADDR_STATUS, 32'h0);
        readCheck("rst_frame_len", ADDR_FRAME_LEN, 32'd64);
        readCheck("rst_ctrl", ADDR_CTRL, 32'h0);
        readCheck("rst_count", ADDR_COUNT, 32'h0);
        $display("[TB] reset checks done");

        // Frame of 4 with 6 offered samples: the last two are discarded
        csrWrite(ADDR_FRAME_LEN, 32'd4);
        csrWrite(ADDR_CTRL, 32'h1);
        readCheck("t1_status_capture", ADDR_STATUS, 32'h1);
        wr_count = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(32'hA000_0000 + i, 1'b1, 1'b0, 1'b1, i < 4);
            if (i == 2) checkOutput("t1_done_early", {31'd0, frame_done}, 32'd0);
            if (i == 3) checkOutput("t1_done_on_time", {31'd0, frame_done}, 32'd1);
        end
        tick();
        checkOutput("t1_wr_count", wr_count, 32'd4);
        readCheck("t1_status_done", ADDR_STATUS, 32'h0000_0406);
        readCheck("t1_count", ADDR_COUNT, 32'h4);
        csrWrite(ADDR_CTRL, 32'h4);
        checkOutput("t1_ack_done", {31'd0, frame_done}, 32'd0);
        readCheck("t1_status_ack", ADDR_STATUS, 32'h0000_0400);

        // Drain; a read while the FIFO reports empty must not decrement
        for (int i = 0; i < 3; i++) applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        readCheck("t1_level_empty_rd", ADDR_STATUS, 32'h0000_0100);
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        readCheck("t1_level_drained", ADDR_STATUS, 32'h0);

        // Unlimited frame, 130 samples into 128 slots
        csrWrite(ADDR_FRAME_LEN, 32'd0);
        csrWrite(ADDR_CTRL, 32'h1);
        wr_count = 0;
        for (int i = 0; i < 130; i++) applyStimulus(32'hB000_0000 + i, 1'b1, 1'b0, 1'b1, i < 128);
        tick();
        checkOutput("t2_wr_count", wr_count, 32'd128);
        readCheck("t2_status_ovf", ADDR_STATUS, 32'h0002_8009);
        readCheck("t2_count", ADDR_COUNT, 32'h80);
        csrWrite(ADDR_CTRL, 32'h10);
        readCheck("t2_status_clr", ADDR_STATUS, 32'h0000_8001);

        // Full FIFO with a simultaneous read: sample accepted, level unchanged
        wr_count = 0;
        applyStimulus(32'hC0DE_0001, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("t3_wr_count", wr_count, 32'd1);
        readCheck("t3_status", ADDR_STATUS, 32'h0000_8001);
        readCheck("t3_count", ADDR_COUNT, 32'h81);

        csrWrite(ADDR_CTRL, 32'h2);
        for (int i = 0; i < 128; i++) applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        readCheck("t3_status_drained", ADDR_STATUS, 32'h0);

        // Continuous mode, three frames of three
        csrWrite(ADDR_FRAME_LEN, 32'd3);
        csrWrite(ADDR_CTRL, 32'h9);
        wr_count = 0;
        for (int i = 0; i < 9; i++) applyStimulus(32'hD000_0000 + i, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("t4_wr_count", wr_count, 32'd9);
        readCheck("t4_status", ADDR_STATUS, 32'h0000_0905);
        readCheck("t4_count", ADDR_COUNT, 32'h0003_0000);
        readCheck("t4_ctrl", ADDR_CTRL, 32'h8);
        checkOutput("t4_frame_done", {31'd0, frame_done}, 32'd1);

        // Abort wins over arm; then re-arm and reset mid-capture
        csrWrite(ADDR_CTRL, 32'h3);
        readCheck("t5_status_abort", ADDR_STATUS, 32'h0000_0904);
        csrWrite(ADDR_CTRL, 32'h1);
        readCheck("t5_status_rearm", ADDR_STATUS, 32'h0000_0901);
        applyStimulus(32'hE000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(32'hE000_0001, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        reset_n = 1'b0;
        #2;
        checkOutput("t5_rst_wrreq", {31'd0, fifo_wrreq}, 32'd0);
        checkOutput("t5_rst_fifo_data", fifo_data, 32'd0);
        checkOutput("t5_rst_readdata", csr_if.readdata, 32'd0);
        checkOutput("t5_rst_frame_done", {31'd0, frame_done}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        readCheck("t5_status", ADDR_STATUS, 32'h0);
        readCheck("t5_frame_len", ADDR_FRAME_LEN, 32'd64);
        readCheck("t5_count", ADDR_COUNT, 32'h0);
        readCheck("t5_ctrl", ADDR_CTRL, 32'h0);

        // Frame completion with ie set, then acknowledge
        csrWrite(ADDR_FRAME_LEN, 32'd2);
        csrWrite(ADDR_CTRL, 32'h21);
`ifdef FIFO_PROM_FRAME_IRQ_EN
        checkOutput("t6_irq_armed", {31'd0, irq}, 32'd0);
`endif
        applyStimulus(32'hF000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(32'hF000_0001, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("t6_frame_done", {31'd0, frame_done}, 32'd1);
`ifdef FIFO_PROM_FRAME_IRQ_EN
        checkOutput("t6_irq_set", {31'd0, irq}, 32'd1);
`endif
        csrWrite(ADDR_CTRL, 32'h24);
        checkOutput("t6_done_ack", {31'd0, frame_done}, 32'd0);
`ifdef FIFO_PROM_FRAME_IRQ_EN
        checkOutput("t6_irq_ack", {31'd0, irq}, 32'd0);
        readCheck("t6_ctrl", ADDR_CTRL, 32'h20);
`else
        readCheck("t6_ctrl", ADDR_CTRL, 32'h0);
`endif
        readCheck("t6_status", ADDR_STATUS, 32'h0000_0200);

        repeat (3) tick();
        checkOutput("sb_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
